fpt_multichannel_frontend: RTL and testbench

- Generalised successor of the single-channel Artix-7 top. It serves NUM_CH independent sensor/motor channel pairs through one shared psi_fpt_core instance.
- Per channel: captures sensor_scrape/motor_command samples into a one-entry holding register.
- Round-robin arbitrates the channels into the core over a valid/ready request port.
- Demultiplexes tagged core responses back to per-channel correction, veto and attention outputs.
- Adds per-channel veto hold-off timers, overflow flags and a heartbeat LED. These behaviours are new in this generation.

---
 rtl/fpt_pkg.sv | 22 ++
 rtl/fpt_rr_arbiter.sv | 42 ++++
 rtl/fpt_multichannel_frontend.sv | 168 ++++++++++++++++
 tb/tb_fpt_multichannel_frontend.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpt_pkg.sv
// Shared constants and helpers for the multichannel FPT frontend.
// Attention-level encodings and the channel-tag width function.
package fpt_pkg;

  localparam logic [1:0] ATTN_IDLE = 2'd0;
  localparam logic [1:0] ATTN_LOW  = 2'd1;
  localparam logic [1:0] ATTN_MED  = 2'd2;
  localparam logic [1:0] ATTN_HIGH = 2'd3;

  localparam int FPT_DATA_W = 16;

  // Reference layout of one holding entry at the default sample width.
  typedef struct packed {
    logic [FPT_DATA_W-1:0] sensor;
    logic [FPT_DATA_W-1:0] motor;
  } fpt_hold_t;

  function automatic int fpt_ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpt_rr_arbiter.sv
// Round-robin pick of the lowest requesting index at or above rr_ptr, wrapping.
// Purely combinational; zero latency, no backpressure of its own.
module fpt_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_any
);

  logic [NUM_CH-1:0] hi;
  logic              found;

  // Scan the upper window first, then fall back to the full vector for the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = |req;
    found     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      hi[i] = req[i] && (CH_W'(i) >= rr_ptr);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && hi[i]) begin
        found        = 1'b1;
        grant[i]     = 1'b1;
        grant_idx    = CH_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i]) begin
        found        = 1'b1;
        grant[i]     = 1'b1;
        grant_idx    = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/fpt_multichannel_frontend.sv
// Multichannel capture, round-robin request port, tagged response demux, veto timers, LEDs.
// Sample to core_req_valid is one cycle min; core_req_* holds while ready=0, newest sample overwrites pending.
module fpt_multichannel_frontend
  import fpt_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int VETO_HOLD = 1024,
  parameter int HB_W      = 24,
  localparam int CH_W     = fpt_ch_width(NUM_CH)
) (
  input  logic                     clk_100mhz,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] sensor_scrape,
  input  logic [NUM_CH-1:0]        sensor_valid,
  input  logic [NUM_CH*DATA_W-1:0] motor_command,
  output logic                     core_req_valid,
  input  logic                     core_req_ready,
  output logic [DATA_W-1:0]        core_req_sensor,
  output logic [DATA_W-1:0]        core_req_motor,
  output logic [CH_W-1:0]          core_req_ch,
  input  logic                     core_rsp_valid,
  input  logic [CH_W-1:0]          core_rsp_ch,
  input  logic [DATA_W-1:0]        core_rsp_correction,
  input  logic                     core_rsp_veto,
  input  logic [1:0]               core_rsp_attention,
  output logic [NUM_CH*DATA_W-1:0] motor_correction,
  output logic [NUM_CH-1:0]        correction_valid,
  output logic [NUM_CH-1:0]        veto_out,
  output logic [2*NUM_CH-1:0]      attention_level,
  output logic [NUM_CH-1:0]        overflow_sticky,
  output logic                     led_red,
  output logic                     led_green
);

  localparam int CNT_W = $clog2(VETO_HOLD + 1);

  typedef struct packed {
    logic [DATA_W-1:0] sensor;
    logic [DATA_W-1:0] motor;
  } entry_t;

  entry_t            hold [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] rsp_hit;
  logic [NUM_CH-1:0] veto_now;
  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] veto_nxt;
  logic [NUM_CH-1:0] arb_req;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   rr_ptr;
  logic              gnt_any;
  logic              req_load;
  logic [HB_W-1:0]   hb_cnt;

  // Tags outside 0..NUM_CH-1 match no channel and are therefore ignored.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      rsp_hit[i]  = core_rsp_valid && (core_rsp_ch == CH_W'(i));
      veto_now[i] = rsp_hit[i] && core_rsp_veto;
      cap[i]      = sensor_valid[i] && !veto_out[i] && !veto_now[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      veto_nxt[i] = veto_out[i];
      cnt_nxt[i]  = cnt[i];
      if (veto_now[i]) begin
        veto_nxt[i] = 1'b1;
        cnt_nxt[i]  = CNT_W'(VETO_HOLD);
      end else if (veto_out[i]) begin
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
        if (cnt[i] == CNT_W'(1)) begin
          veto_nxt[i] = 1'b0;
        end
      end
    end
  end

  // A channel being flushed by a veto this cycle must not win arbitration.
  assign arb_req  = pend & ~veto_now;
  assign req_load = !core_req_valid || core_req_ready;

  fpt_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req       (arb_req),
    .rr_ptr    (rr_ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      pend             <= '0;
      overflow_sticky  <= '0;
      rr_ptr           <= '0;
      core_req_valid   <= 1'b0;
      core_req_sensor  <= '0;
      core_req_motor   <= '0;
      core_req_ch      <= '0;
      motor_correction <= '0;
      correction_valid <= '0;
      attention_level  <= {NUM_CH{ATTN_IDLE}};
      veto_out         <= '0;
      led_red          <= 1'b0;
      led_green        <= 1'b0;
      hb_cnt           <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i]) begin
          hold[i].sensor <= sensor_scrape[i*DATA_W +: DATA_W];
          hold[i].motor  <= motor_command[i*DATA_W +: DATA_W];
        end
        if (cap[i] && pend[i] && !(req_load && gnt[i])) begin
          overflow_sticky[i] <= 1'b1;
        end
        if (veto_now[i]) begin
          pend[i] <= 1'b0;
        end else if (cap[i]) begin
          pend[i] <= 1'b1;
        end else if (req_load && gnt[i]) begin
          pend[i] <= 1'b0;
        end
        if (rsp_hit[i]) begin
          motor_correction[i*DATA_W +: DATA_W] <= core_rsp_correction;
          attention_level[i*2 +: 2]            <= core_rsp_attention;
        end
        cnt[i] <= cnt_nxt[i];
      end
      correction_valid <= rsp_hit;
      veto_out         <= veto_nxt;

      // The granted entry leaves with its old contents; a same-cycle capture refills it.
      if (req_load) begin
        core_req_valid <= gnt_any;
        if (gnt_any) begin
          core_req_sensor <= hold[gnt_idx].sensor;
          core_req_motor  <= hold[gnt_idx].motor;
          core_req_ch     <= gnt_idx;
          rr_ptr          <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        end
      end

      led_red <= |veto_nxt;
      if (|veto_nxt) begin
        hb_cnt    <= '0;
        led_green <= 1'b0;
      end else begin
        hb_cnt <= hb_cnt + HB_W'(1);
        if (&hb_cnt) begin
          led_green <= !led_green;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpt_multichannel_frontend.sv
// Scoreboard bench for fpt_multichannel_frontend at NUM_CH=4, DATA_W=16, VETO_HOLD=8, HB_W=4.
// Stimulus pushes expected requests/responses; a negedge monitor pops and compares.
module tb_fpt_multichannel_frontend;
  import fpt_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 16;
  localparam int VETO_HOLD = 8;
  localparam int HB_W      = 4;

  logic        clk_100mhz = 1'b0;
  logic        rst;
  logic [63:0] sensor_scrape;
  logic [3:0]  sensor_valid;
  logic [63:0] motor_command;
  logic        core_req_valid;
  logic        core_req_ready;
  logic [15:0] core_req_sensor;
  logic [15:0] core_req_motor;
  logic [1:0]  core_req_ch;
  logic        core_rsp_valid;
  logic [1:0]  core_rsp_ch;
  logic [15:0] core_rsp_correction;
  logic        core_rsp_veto;
  logic [1:0]  core_rsp_attention;
  logic [63:0] motor_correction;
  logic [3:0]  correction_valid;
  logic [3:0]  veto_out;
  logic [7:0]  attention_level;
  logic [3:0]  overflow_sticky;
  logic        led_red;
  logic        led_green;

  always #5 clk_100mhz = ~clk_100mhz;

  fpt_multichannel_frontend #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .VETO_HOLD (VETO_HOLD),
    .HB_W      (HB_W)
  ) dut (
    .clk_100mhz          (clk_100mhz),
    .rst                 (rst),
    .sensor_scrape       (sensor_scrape),
    .sensor_valid        (sensor_valid),
    .motor_command       (motor_command),
    .core_req_valid      (core_req_valid),
    .core_req_ready      (core_req_ready),
    .core_req_sensor     (core_req_sensor),
    .core_req_motor      (core_req_motor),
    .core_req_ch         (core_req_ch),
    .core_rsp_valid      (core_rsp_valid),
    .core_rsp_ch         (core_rsp_ch),
    .core_rsp_correction (core_rsp_correction),
    .core_rsp_veto       (core_rsp_veto),
    .core_rsp_attention  (core_rsp_attention),
    .motor_correction    (motor_correction),
    .correction_valid    (correction_valid),
    .veto_out            (veto_out),
    .attention_level     (attention_level),
    .overflow_sticky     (overflow_sticky),
    .led_red             (led_red),
    .led_green           (led_green)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] sensor;
    logic [15:0] motor;
  } req_t;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] corr;
    logic [1:0]  attn;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic push_req(input int ch, input logic [15:0] s, input logic [15:0] m);
    req_t r;
    r.ch     = 2'(ch);
    r.sensor = s;
    r.motor  = m;
    exp_req.push_back(r);
  endtask

  task automatic strobe(input logic [3:0] mask, input logic [63:0] s, input logic [63:0] m);
    sensor_valid  = mask;
    sensor_scrape = s;
    motor_command = m;
    tick();
    sensor_valid  = 4'b0000;
  endtask

  task automatic send_rsp(input int ch, input logic [15:0] corr, input logic veto, input logic [1:0] attn);
    rsp_t r;
    r.ch                = 2'(ch);
    r.corr              = corr;
    r.attn              = attn;
    exp_rsp.push_back(r);
    core_rsp_valid      = 1'b1;
    core_rsp_ch         = 2'(ch);
    core_rsp_correction = corr;
    core_rsp_veto       = veto;
    core_rsp_attention  = attn;
    tick();
    core_rsp_valid      = 1'b0;
    core_rsp_veto       = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"}, {core_req_valid, core_req_sensor, core_req_motor, core_req_ch}, 64'h0);
    chk({tag, "_corr"}, motor_correction, 64'h0);
    chk({tag, "_misc"}, {correction_valid, veto_out, attention_level, overflow_sticky, led_red, led_green}, 64'h0);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    exp_req.delete();
    exp_rsp.delete();
    tick();
    @(negedge clk_100mhz);
    check_zero(tag);
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_req.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_req.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending requests want 0", exp_req.size());
      exp_req.delete();
    end
  endtask

  always @(negedge clk_100mhz) begin
    req_t er;
    rsp_t es;
    if (!rst) begin
      if (core_req_valid && core_req_ready) begin
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got ch %0d sensor %h want no request", core_req_ch, core_req_sensor);
        end else begin
          er = exp_req.pop_front();
          chk("req", {core_req_ch, core_req_sensor, core_req_motor}, er);
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (correction_valid[i]) begin
          if (exp_rsp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_corr: got ch %0d want no correction", i);
          end else begin
            es = exp_rsp.pop_front();
            chk("corr", {2'(i), motor_correction[i*16 +: 16], attention_level[i*2 +: 2]}, es);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst                 = 1'b1;
    sensor_valid        = 4'b0000;
    sensor_scrape       = 64'h0;
    motor_command       = 64'h0;
    core_req_ready      = 1'b0;
    core_rsp_valid      = 1'b0;
    core_rsp_ch         = 2'd0;
    core_rsp_correction = 16'h0;
    core_rsp_veto       = 1'b0;
    core_rsp_attention  = 2'd0;

    // Single request, latency, and correction pulse on channel 2.
    reset_pulse("rst0");
    core_req_ready = 1'b1;
    push_req(2, 16'h1234, 16'h00AA);
    strobe(4'b0100, {16'h0, 16'h1234, 32'h0}, {16'h0, 16'h00AA, 32'h0});
    @(negedge clk_100mhz);
    chk("t1_not_same_cycle", core_req_valid, 1'b0);
    tick();
    @(negedge clk_100mhz);
    chk("t1_req_vld_ch", {core_req_valid, core_req_ch}, {1'b1, 2'd2});
    tick();
    send_rsp(2, 16'h0F0F, 1'b0, ATTN_MED);
    @(negedge clk_100mhz);
    chk("t1_corr_pulse", correction_valid, 4'b0100);
    chk("t1_corr_val", motor_correction[47:32], 16'h0F0F);
    chk("t1_attn", attention_level[5:4], ATTN_MED);
    tick();
    @(negedge clk_100mhz);
    chk("t1_corr_one_cycle", correction_valid, 4'b0000);
    chk("t1_req_idle", core_req_valid, 1'b0);

    // All four channels at once, then 0 and 3 with rr_ptr back at 0.
    reset_pulse("rst1");
    core_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_req(i, 16'h0100 + 16'(i) * 16'h0011, 16'h0200 + 16'(i));
    strobe(4'b1111, {16'h0133, 16'h0122, 16'h0111, 16'h0100}, {16'h0203, 16'h0202, 16'h0201, 16'h0200});
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk_100mhz);
      chk("t2_consecutive", {core_req_valid, core_req_ch}, {1'b1, 2'(k)});
    end
    tick();
    push_req(0, 16'h0400, 16'h0500);
    push_req(3, 16'h0403, 16'h0503);
    strobe(4'b1001, {16'h0403, 32'h0, 16'h0400}, {16'h0503, 32'h0, 16'h0500});
    wait_drain(20);

    // Overwrite of a pending sample while the request port is stalled.
    reset_pulse("rst2");
    core_req_ready = 1'b0;
    push_req(0, 16'h00A0, 16'h0A00);
    strobe(4'b0001, {48'h0, 16'h00A0}, {48'h0, 16'h0A00});
    for (int v = 1; v <= 3; v++) begin
      strobe(4'b0010, {32'h0, 16'(v), 16'h0}, {32'h0, 16'h0B00 + 16'(v), 16'h0});
    end
    push_req(1, 16'h0003, 16'h0B03);
    @(negedge clk_100mhz);
    chk("t3_overflow", overflow_sticky, 4'b0010);
    chk("t3_stalled", {core_req_valid, core_req_ch, core_req_sensor}, {1'b1, 2'd0, 16'h00A0});
    tick();
    core_req_ready = 1'b1;
    wait_drain(20);
    chk("t3_overflow_sticky", overflow_sticky, 4'b0010);

    // Veto window on channel 1, reload at cycle 5, strobes dropped inside.
    send_rsp(1, 16'h1111, 1'b1, ATTN_HIGH);
    sensor_scrape = {32'h0, 16'h00EE, 16'h0};
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_100mhz);
      chk("t4_veto_first", {veto_out, led_red, led_green}, {4'b0010, 1'b1, 1'b0});
      sensor_valid = (k == 2) ? 4'b0010 : 4'b0000;
      tick();
    end
    sensor_valid = 4'b0000;
    send_rsp(1, 16'h2222, 1'b1, ATTN_LOW);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk_100mhz);
      if (k < 8) chk("t4_veto_reload", {veto_out, led_red}, {4'b0010, 1'b1});
      else chk("t4_veto_end", {veto_out, led_red}, {4'b0000, 1'b0});
      sensor_valid = (k == 3) ? 4'b0010 : 4'b0000;
      tick();
    end
    sensor_valid = 4'b0000;
    chk("t4_no_flag_on_drop", overflow_sticky, 4'b0010);
    push_req(1, 16'h0055, 16'h0B55);
    strobe(4'b0010, {32'h0, 16'h0055, 16'h0}, {32'h0, 16'h0B55, 16'h0});
    wait_drain(20);

    // Reset while a request to channel 1 is stalled; rr_ptr must return to 0.
    core_req_ready = 1'b0;
    strobe(4'b0010, {32'h0, 16'h0077, 16'h0}, {32'h0, 16'h0B77, 16'h0});
    tick();
    @(negedge clk_100mhz);
    chk("t5_held", {core_req_valid, core_req_ch}, {1'b1, 2'd1});
    tick();
    reset_pulse("t5_rst");
    core_req_ready = 1'b1;
    push_req(0, 16'h0101, 16'h0C00);
    push_req(3, 16'h0303, 16'h0C03);
    strobe(4'b1001, {16'h0303, 32'h0, 16'h0101}, {16'h0C03, 32'h0, 16'h0C00});
    wait_drain(20);

    // Heartbeat every 16 cycles, then suppressed during a veto.
    reset_pulse("rst3");
    core_req_ready = 1'b0;
    for (int c = 1; c <= 56; c++) begin
      tick();
      @(negedge clk_100mhz);
      chk("t6_heartbeat", led_green, 64'((c / 16) % 2));
    end
    send_rsp(0, 16'h0000, 1'b1, ATTN_LOW);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk_100mhz);
      chk("t6_green_veto", {led_green, led_red}, {1'b0, (k < 8)});
      tick();
    end

    tick();
    chk("end_req_queue", 64'(exp_req.size()), 64'h0);
    chk("end_rsp_queue", 64'(exp_rsp.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
